// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage: req/ack bus master with byte lanes,
// datapath stall, load extension and a bus timeout.
//
// state | meaning
// IDLE  | waiting for MemRead/MemWrite; decodes size/alignment
// REQ   | bus request held until ack or timeout
// DONE  | one-cycle completion (oDone, oFault on timeout)
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oStall,
  output logic        oDone,
  output logic        oFault,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [3:0]  oMemBe,
  output logic [31:0] oMemWdata,
  input  logic        iMemAck,
  input  logic [31:0] iMemRdata
);

  localparam logic [7:0] TimeoutLoad = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, nextState;
  logic [7:0]  timer;
  logic [1:0]  lane;
  logic [1:0]  size;
  logic        isSigned;
  logic        timedOut;
  logic        access;
  logic        legal;
  logic        timerExpired;
  logic [3:0]  byteEn;
  logic [31:0] storeData;
  logic [31:0] laneData;
  logic [31:0] extData;

  assign access       = iMemRead | iMemWrite;
  assign timerExpired = (timer == 8'd1);

  // Illegal encodings and misaligned addresses both fault without a bus cycle.
  always_comb begin
    legal = 1'b0;
    case (iFunct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~iAddress[0];
      3'b010:  legal = (iAddress[1:0] == 2'b00);
      3'b100:  legal = ~iMemWrite;
      3'b101:  legal = ~iMemWrite & ~iAddress[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    byteEn    = 4'b1111;
    storeData = iWriteData;
    case (iFunct3[1:0])
      2'b00: begin
        byteEn    = 4'b0001 << iAddress[1:0];
        storeData = {4{iWriteData[7:0]}};
      end
      2'b01: begin
        byteEn    = 4'b0011 << iAddress[1:0];
        storeData = {2{iWriteData[15:0]}};
      end
      default: begin
        byteEn    = 4'b1111;
        storeData = iWriteData;
      end
    endcase
  end

  always_comb begin
    laneData = iMemRdata >> {lane, 3'b000};
    case (size)
      2'b00:   extData = isSigned ? {{24{laneData[7]}}, laneData[7:0]}
                                  : {24'b0, laneData[7:0]};
      2'b01:   extData = isSigned ? {{16{laneData[15]}}, laneData[15:0]}
                                  : {16'b0, laneData[15:0]};
      default: extData = iMemRdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    oStall    = 1'b0;
    oDone     = 1'b0;
    oFault    = 1'b0;
    oMemReq   = 1'b0;
    case (state)
      IDLE: begin
        if (access && legal) begin
          oStall    = 1'b1;
          nextState = REQ;
        end else if (access) begin
          oFault = 1'b1;
        end
      end
      REQ: begin
        oStall  = 1'b1;
        oMemReq = 1'b1;
        if (iMemAck || timerExpired) nextState = DONE;
      end
      DONE: begin
        oDone     = 1'b1;
        oFault    = timedOut;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Timeout timer counts down from TIMEOUT_CYCLES; terminal count is 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer     <= 8'd0;
      lane      <= 2'd0;
      size      <= 2'd0;
      isSigned  <= 1'b0;
      timedOut  <= 1'b0;
      oReadData <= 32'd0;
      oMemWe    <= 1'b0;
      oMemAddr  <= 32'd0;
      oMemBe    <= 4'd0;
      oMemWdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (access && legal) begin
            oMemAddr  <= {iAddress[31:2], 2'b00};
            oMemWe    <= iMemWrite;
            oMemBe    <= byteEn;
            oMemWdata <= storeData;
            lane      <= iAddress[1:0];
            size      <= iFunct3[1:0];
            isSigned  <= ~iFunct3[2];
            timer     <= TimeoutLoad;
            timedOut  <= 1'b0;
          end
        end
        REQ: begin
          if (iMemAck) begin
            oReadData <= extData;
          end else if (timerExpired) begin
            oReadData <= 32'd0;
            timedOut  <= 1'b1;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against an arithmetic
// reference model of access sizing, lane selection and extension.
module tb_load_store_unit;

  localparam int Timeout = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        iMemRead, iMemWrite, iMemAck;
  logic [2:0]  iFunct3;
  logic [31:0] iAddress, iWriteData, iMemRdata;
  logic [31:0] oReadData, oMemAddr, oMemWdata;
  logic [3:0]  oMemBe;
  logic        oStall, oDone, oFault, oMemReq, oMemWe;

  int nCompared = 0;
  int nMismatched = 0;

  load_store_unit #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clock(clock), .reset(reset),
    .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iFunct3(iFunct3),
    .iAddress(iAddress), .iWriteData(iWriteData),
    .oReadData(oReadData), .oStall(oStall), .oDone(oDone), .oFault(oFault),
    .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemBe(oMemBe),
    .oMemWdata(oMemWdata), .iMemAck(iMemAck), .iMemRdata(iMemRdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " readData"}, oReadData, 32'd0);
    check({tag, " stall"}, {31'd0, oStall}, 32'd0);
    check({tag, " done"}, {31'd0, oDone}, 32'd0);
    check({tag, " fault"}, {31'd0, oFault}, 32'd0);
    check({tag, " req"}, {31'd0, oMemReq}, 32'd0);
    check({tag, " we"}, {31'd0, oMemWe}, 32'd0);
    check({tag, " addr"}, oMemAddr, 32'd0);
    check({tag, " be"}, {28'd0, oMemBe}, 32'd0);
    check({tag, " wdata"}, oMemWdata, 32'd0);
  endtask

  // One datapath instruction; ackDelay = REQ cycles without ack before the ack.
  task automatic doAccess(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int ackDelay);
    int          bytes, lane, reqCycles, stalls;
    bit          sgn, isAccess, legal, tmo;
    logic [31:0] expAddr, expWd, expRd, v, full;
    logic [3:0]  expBe;

    bytes = 0; sgn = 0;
    case (f3)
      3'd0: begin bytes = 1; sgn = 1; end
      3'd1: begin bytes = 2; sgn = 1; end
      3'd2: begin bytes = 4; sgn = 0; end
      3'd4: bytes = wr ? 0 : 1;
      3'd5: bytes = wr ? 0 : 2;
      default: bytes = 0;
    endcase
    isAccess = rd || wr;
    legal    = isAccess && (bytes != 0) && ((addr % bytes) == 0);
    lane     = int'(addr % 4);
    expAddr  = addr - (addr % 4);
    expBe    = (bytes == 4) ? 4'd15 : 4'(((1 << bytes) - 1) << lane);
    if (bytes == 1)      expWd = (wd % 256) * 32'h0101_0101;
    else if (bytes == 2) expWd = (wd % 65536) * 32'h0001_0001;
    else                 expWd = wd;
    if (bytes == 4 || bytes == 0) begin
      expRd = rdata;
    end else begin
      full = 32'(1) << (8 * bytes);
      v = (rdata >> (8 * lane)) % full;
      if (sgn && v >= (full / 2)) v = v - full;
      expRd = v;
    end
    tmo       = ackDelay >= Timeout;
    reqCycles = tmo ? Timeout : ackDelay + 1;
    if (tmo) expRd = 32'd0;

    @(posedge clock); #1;
    iMemRead = rd; iMemWrite = wr; iFunct3 = f3; iAddress = addr; iWriteData = wd;
    iMemAck = 1'($urandom); iMemRdata = $urandom;
    @(negedge clock);
    check("idle stall", {31'd0, oStall}, {31'd0, legal});
    check("idle fault", {31'd0, oFault}, {31'd0, isAccess && !legal});
    check("idle req", {31'd0, oMemReq}, 32'd0);
    check("idle done", {31'd0, oDone}, 32'd0);
    if (!legal) begin
      @(posedge clock); #1;
      iMemRead = 0; iMemWrite = 0; iMemAck = 0;
      @(negedge clock);
      check("after fault req", {31'd0, oMemReq}, 32'd0);
      check("after fault stall", {31'd0, oStall}, 32'd0);
      check("after fault done", {31'd0, oDone}, 32'd0);
      return;
    end

    stalls = 1;
    for (int c = 0; c < reqCycles; c++) begin
      @(posedge clock); #1;
      iMemRead = 1'($urandom); iMemWrite = 1'($urandom); iFunct3 = 3'($urandom);
      iAddress = $urandom; iWriteData = $urandom;
      iMemAck = (!tmo && c == ackDelay);
      iMemRdata = iMemAck ? rdata : $urandom;
      @(negedge clock);
      if (oStall) stalls++;
      check("req req", {31'd0, oMemReq}, 32'd1);
      check("req done", {31'd0, oDone}, 32'd0);
      check("req fault", {31'd0, oFault}, 32'd0);
      check("req addr", oMemAddr, expAddr);
      check("req be", {28'd0, oMemBe}, {28'd0, expBe});
      check("req we", {31'd0, oMemWe}, {31'd0, wr});
      if (wr) check("req wdata", oMemWdata, expWd);
    end

    @(posedge clock); #1;
    iMemRead = 0; iMemWrite = 0; iMemAck = 1'($urandom); iMemRdata = $urandom;
    @(negedge clock);
    check("stall cycles", stalls, 1 + reqCycles);
    check("done done", {31'd0, oDone}, 32'd1);
    check("done stall", {31'd0, oStall}, 32'd0);
    check("done req", {31'd0, oMemReq}, 32'd0);
    check("done fault", {31'd0, oFault}, {31'd0, tmo});
    if (!wr || tmo) check("done readData", oReadData, expRd);
    @(posedge clock); #1;
    iMemAck = 0;
    @(negedge clock);
    check("post done", {31'd0, oDone}, 32'd0);
    check("post fault", {31'd0, oFault}, 32'd0);
    if (!wr || tmo) check("held readData", oReadData, expRd);
  endtask

  initial begin
    reset = 1; iMemRead = 0; iMemWrite = 0; iFunct3 = 0; iAddress = 0;
    iWriteData = 0; iMemAck = 0; iMemRdata = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkAllZero("reset");
    @(posedge clock); #1 reset = 0;

    doAccess(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 2);
    doAccess(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF_FFFF, 0);
    check("LB value", oReadData, 32'hFFFF_FF80);
    doAccess(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF_FFFF, 0);
    check("LBU value", oReadData, 32'h0000_0080);
    doAccess(1, 0, 3'b101, 32'h202, 32'h0, 32'h8001_0000, 0);
    check("LHU value", oReadData, 32'h0000_8001);
    doAccess(0, 1, 3'b001, 32'h12, 32'h0000_ABCD, 32'h0, 0);
    check("SH wdata", oMemWdata, 32'hABCD_ABCD);
    check("SH be", {28'd0, oMemBe}, 32'hC);
    doAccess(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    doAccess(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    doAccess(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    doAccess(1, 1, 3'b010, 32'h204, 32'h1234_5678, 32'h0, 1);
    doAccess(1, 0, 3'b010, 32'h300, 32'h0, 32'h1111_2222, 10);
    doAccess(1, 0, 3'b001, 32'h302, 32'h0, 32'h8765_4321, Timeout - 1);
    doAccess(0, 0, 3'b010, 32'h300, 32'h0, 32'h0, 0);

    for (int i = 0; i < 300; i++)
      doAccess(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom,
               $urandom, int'($urandom_range(0, 5)));

    // Reset in the middle of a bus request.
    @(posedge clock); #1;
    iMemRead = 1; iMemWrite = 0; iFunct3 = 3'b010; iAddress = 32'h40;
    @(negedge clock);
    @(posedge clock); #1;
    iMemRead = 0; iMemAck = 0;
    @(negedge clock);
    check("pre-reset req", {31'd0, oMemReq}, 32'd1);
    @(posedge clock); #1 reset = 1;
    @(negedge clock);
    @(negedge clock);
    checkAllZero("mid-req reset");
    @(posedge clock); #1 reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("no done after reset", {31'd0, oDone}, 32'd0);
      check("no req after reset", {31'd0, oMemReq}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage downstream of the single-cycle datapath. It consumes the datapath's MemRead/MemWrite controls, the ALU result as the effective address, rs2 as store data and funct3 as the access size. It drives a req/ack memory bus with byte enables, stalls the datapath until the access completes, and returns sign- or zero-extended load data for the rd write-back mux.

## Interface
- TIMEOUT_CYCLES, 255: REQ cycles without ack before abort (1..255, 8-bit counter)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- iMemRead  in  1  current instruction is a load
- iMemWrite  in  1  current instruction is a store; wins if both high
- iFunct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- iAddress  in  32  effective address (ALU result)
- iWriteData  in  32  store data (rs2)
- oReadData  out  32  extended load data, valid in DONE, held afterward
- oStall  out  1  datapath must hold pc/regfile write while high
- oDone  out  1  one-cycle pulse, access finished
- oFault  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout
- oMemReq  out  1  bus request, held until ack
- oMemWe  out  1  1 = write
- oMemAddr  out  32  word address {addr[31:2],2'b00}
- oMemBe  out  4  byte enables
- oMemWdata  out  32  lane-replicated store data
- iMemAck  in  1  bus completion, sampled only in REQ
- iMemRdata  in  32  read word, valid with iMemAck

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, no access (iMemRead=iMemWrite=0): oStall=0, outputs idle.
- IDLE, access, illegal funct3 (011,110,111; or 100/101 with store): oFault=1 this cycle, oStall=0, no bus cycle, stay IDLE.
- IDLE, access, misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): same as illegal, oFault=1, oStall=0.
- IDLE, legal access: oStall=1 combinationally; at edge register oMemAddr, oMemWe, oMemBe, oMemWdata, lane=addr[1:0], size/sign; go REQ; timeout counter cleared.
- REQ: oMemReq=1, oStall=1. iMemAck=1 -> capture extended data into oReadData, go DONE. Else counter++; counter reaching TIMEOUT_CYCLES -> oReadData=0, fault flag set, go DONE.
- DONE: oStall=0, oDone=1, oFault=1 if timed out, oMemReq=0; inputs ignored; next state IDLE.
- Byte enables: B 4'b0001<<lane; H 4'b0011<<lane; W 4'b1111.
- Store data: B {4{wd[7:0]}}; H {2{wd[15:0]}}; W wd.
- Load extend: B/H sign-extend selected lane bits; BU/HU zero-extend; W unchanged.
- Ack outside REQ ignored.

## Timing
- Reset: state IDLE, counter 0, all outputs 0 (oReadData, oMemAddr, oMemWdata, oMemBe included). Reset during REQ drops oMemReq next cycle; no oDone.
- Min latency: IDLE (stall) -> REQ (ack same cycle) -> DONE: 3 cycles per memory instruction; pc advances on the DONE edge.
- Each extra cycle of ack delay adds one REQ cycle.
- Bus signals stable throughout REQ; oMemReq deasserts the edge after ack.
- Timeout: after TIMEOUT_CYCLES REQ cycles with no ack, DONE entered next edge.
- Fault and oDone are never asserted together except on timeout (DONE with oFault=1).

## Test plan
- LW addr 0x100, ack after 2 REQ cycles, rdata 0xDEADBEEF -> oMemAddr 0x100, oMemBe 1111, 4 stall cycles total, DONE oReadData 0xDEADBEEF, oDone one pulse.
- LB addr 0x203, rdata 0x80FFFFFF -> oMemBe 1000, oReadData 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x202 rdata 0x80010000 -> 0x00008001.
- SH addr 0x12, wd 0x0000ABCD, immediate ack -> oMemWe 1, oMemAddr 0x10, oMemBe 1100, oMemWdata 0xABCDABCD, 3 cycles.
- LW addr 0x101 and funct3 011 -> oFault pulse, oStall 0, oMemReq never high.
- TIMEOUT_CYCLES=4, no ack -> exactly 4 REQ cycles, then DONE with oFault=1, oReadData 0; reset asserted mid-REQ -> oMemReq 0 next cycle, all outputs 0.
